// File: rtl/if_ctrl_pkg.sv
// Shared widths and constants for the instruction-fetch control slice.
// The load-use check lives here so the hazard unit and fetch agree on its definition.
package if_ctrl_pkg;

   localparam int ImmWidth  = 64;
   localparam int InstWidth = 32;

   localparam logic [31:0] Nop = 32'h0000_0013;

   function automatic logic isLoadUse(
      input logic       memRead,
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2
   );
      return memRead && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/if_ctrl_if.sv
// Instruction-memory fetch channel: request handshake plus a response with no backpressure.
interface if_ctrl_if #(
   parameter int PC_WIDTH   = 64,
   parameter int INST_WIDTH = 32
) ();

   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [PC_WIDTH-1:0]   imem_req_addr;
   logic                  imem_rsp_valid;
   logic [INST_WIDTH-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/if_ctrl_reg.sv
// Generic enabled register with synchronous active-high reset to a parameterised value.
module Reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RESET_VAL;
      end else if (en) begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/if_ctrl.sv
// Fetch-stage controller: issues one outstanding imem request, buffers a response during a
// load-use stall, squashes in-flight fetches on redirect, and drives the IF/ID next-state controls.
module if_ctrl
   import if_ctrl_pkg::*;
#(
   parameter int                  PC_WIDTH   = ImmWidth,
   parameter int                  INST_WIDTH = InstWidth,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(64'h8000_0000)
) (
   input  logic                  clk,
   input  logic                  rst,

   if_ctrl_if.master             imem,

   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,

   input  logic                  ex_mem_read,
   input  logic [4:0]            ex_rd,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,

   output logic                  ifid_wen,
   output logic [PC_WIDTH-1:0]   ifid_pc,
   output logic [INST_WIDTH-1:0] ifid_inst,
   output logic                  ifid_flush,
   output logic                  idex_flush
);

   localparam logic [1:0] StReq  = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StDrop = 2'd2;
   localparam logic [1:0] StHold = 2'd3;

   localparam logic [INST_WIDTH-1:0] NopInst = INST_WIDTH'(Nop);

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [PC_WIDTH-1:0]   pc_d;
   logic                  pcEn;
   logic [INST_WIDTH-1:0] instBuf_q;
   logic                  instBufEn;

   logic                  stall;
   logic                  deliver;
   logic [INST_WIDTH-1:0] deliverInst;
   logic                  reqValid;
   logic [PC_WIDTH-1:0]   pcPlus4;

   assign stall   = isLoadUse(ex_mem_read, ex_rd, id_rs1, id_rs2);
   assign pcPlus4 = pc_q + PC_WIDTH'(4);

   Reg #(
      .WIDTH     (PC_WIDTH),
      .RESET_VAL (RESET_PC)
   ) pcReg (
      .clk (clk),
      .rst (rst),
      .en  (pcEn),
      .d   (pc_d),
      .q   (pc_q)
   );

   Reg #(
      .WIDTH     (INST_WIDTH),
      .RESET_VAL ('0)
   ) instBufReg (
      .clk (clk),
      .rst (rst),
      .en  (instBufEn),
      .d   (imem.imem_rsp_data),
      .q   (instBuf_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StReq;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect always wins; a stall only matters once a response is in hand (WAIT or HOLD).
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pcEn        = 1'b0;
      instBufEn   = 1'b0;
      deliver     = 1'b0;
      deliverInst = imem.imem_rsp_data;
      reqValid    = 1'b0;

      case (state_q)
         StReq: begin
            reqValid = 1'b1;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               pcEn    = 1'b1;
               state_d = imem.imem_req_ready ? StDrop : StReq;
            end else if (imem.imem_req_ready) begin
               state_d = StWait;
            end
         end

         StWait: begin
            if (imem.imem_rsp_valid) begin
               if (redirect_valid) begin
                  pc_d    = redirect_pc;
                  pcEn    = 1'b1;
                  state_d = StReq;
               end else if (!stall) begin
                  deliver = 1'b1;
                  pc_d    = pcPlus4;
                  pcEn    = 1'b1;
                  state_d = StReq;
               end else begin
                  instBufEn = 1'b1;
                  state_d   = StHold;
               end
            end else if (redirect_valid) begin
               pc_d    = redirect_pc;
               pcEn    = 1'b1;
               state_d = StDrop;
            end
         end

         StDrop: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
               pcEn = 1'b1;
            end
            if (imem.imem_rsp_valid) begin
               state_d = StReq;
            end
         end

         StHold: begin
            deliverInst = instBuf_q;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               pcEn    = 1'b1;
               state_d = StReq;
            end else if (!stall) begin
               deliver = 1'b1;
               pc_d    = pcPlus4;
               pcEn    = 1'b1;
               state_d = StReq;
            end
         end

         default: begin
            state_d = StReq;
         end
      endcase
   end

   // IF/ID controls; whenever IF/ID is flushed it sees a NOP at pc 0.
   always_comb begin
      ifid_wen   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b0;
      ifid_pc    = '0;
      ifid_inst  = NopInst;

      if (rst) begin
         ifid_wen   = 1'b1;
         ifid_flush = 1'b1;
         idex_flush = 1'b0;
      end else if (redirect_valid) begin
         ifid_wen   = 1'b1;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (stall) begin
         ifid_wen   = 1'b0;
         ifid_flush = 1'b0;
         idex_flush = 1'b1;
      end else if (deliver) begin
         ifid_wen   = 1'b1;
         ifid_flush = 1'b0;
         ifid_pc    = pc_q;
         ifid_inst  = deliverInst;
      end
   end

   assign imem.imem_req_valid = reqValid && !rst;
   assign imem.imem_req_addr  = rst ? '0 : pc_q;

endmodule

// File: tb/tb_if_ctrl.sv
// Directed self-checking bench for if_ctrl: fetch, redirect, load-use hold, x0 and reset cases.
module tb_if_ctrl;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        ifid_wen;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_inst;
   logic        ifid_flush;
   logic        idex_flush;

   int checks;
   int errors;

   if_ctrl_if #(.PC_WIDTH(64), .INST_WIDTH(32)) imem ();

   if_ctrl #(
      .PC_WIDTH   (64),
      .INST_WIDTH (32),
      .RESET_PC   (64'h8000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ex_mem_read    (ex_mem_read),
      .ex_rd          (ex_rd),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .ifid_wen       (ifid_wen),
      .ifid_pc        (ifid_pc),
      .ifid_inst      (ifid_inst),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      ex_mem_read = 1'b0;
      ex_rd = '0;
      id_rs1 = '0;
      id_rs2 = '0;
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got %0h exp 0", imem.imem_req_valid); end
      checks++; if (ifid_flush !== 1'b1) begin errors++; $display("[TB] FAIL reset_ifid_flush got %0h exp 1", ifid_flush); end
      checks++; if (ifid_wen !== 1'b1) begin errors++; $display("[TB] FAIL reset_ifid_wen got %0h exp 1", ifid_wen); end
      checks++; if (ifid_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_ifid_inst got %h exp 00000013", ifid_inst); end
      checks++; if (idex_flush !== 1'b0 || ifid_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_idex_pc got %0h/%h exp 0/0", idex_flush, ifid_pc); end
   endtask

   task automatic test_fetch();
      @(negedge clk);
      rst = 1'b0;
      imem.imem_req_ready = 1'b1;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL fetch_req0 got %0h/%h exp 1/80000000", imem.imem_req_valid, imem.imem_req_addr); end
      checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL fetch_bubble got %0h/%0h exp 1/0", ifid_flush, idex_flush); end
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'h00a0_0093;
      #1;
      checks++; if (ifid_wen !== 1'b1 || ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL fetch_deliver_ctl got %0h/%0h exp 1/0", ifid_wen, ifid_flush); end
      checks++; if (ifid_pc !== 64'h8000_0000 || ifid_inst !== 32'h00a0_0093) begin errors++; $display("[TB] FAIL fetch_deliver_data got %h/%h exp 80000000/00a00093", ifid_pc, ifid_inst); end
      checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_wait_noreq got %0h exp 0", imem.imem_req_valid); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0004) begin errors++; $display("[TB] FAIL fetch_req1 got %0h/%h exp 1/80000004", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      @(negedge clk);
      imem.imem_req_ready = 1'b1;
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_0100;
      #1;
      checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b1 || ifid_wen !== 1'b1) begin errors++; $display("[TB] FAIL redir_wait_ctl got %0h/%0h/%0h exp 1/1/1", ifid_flush, idex_flush, ifid_wen); end
      @(negedge clk);
      redirect_valid = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'h1111_1111;
      #1;
      checks++; if (ifid_flush !== 1'b1 || ifid_inst !== 32'h0000_0013 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop got %0h/%h/%0h exp 1/00000013/0", ifid_flush, ifid_inst, idex_flush); end
      checks++; if (imem.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop_noreq got %0h exp 0", imem.imem_req_valid); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0100) begin errors++; $display("[TB] FAIL redir_newaddr got %0h/%h exp 1/80000100", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_stall_hold();
      @(negedge clk);
      imem.imem_req_ready = 1'b1;
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'h0011_2233;
      ex_mem_read = 1'b1;
      ex_rd = 5'd5;
      id_rs1 = 5'd5;
      id_rs2 = 5'd0;
      #1;
      checks++; if (ifid_wen !== 1'b0 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL stall_ctl got %0h/%0h exp 0/1", ifid_wen, idex_flush); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      #1;
      checks++; if (ifid_wen !== 1'b0 || imem.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_stay got %0h/%0h exp 0/0", ifid_wen, imem.imem_req_valid); end
      @(negedge clk);
      ex_mem_read = 1'b0;
      #1;
      checks++; if (ifid_wen !== 1'b1 || ifid_flush !== 1'b0 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_ctl got %0h/%0h/%0h exp 1/0/0", ifid_wen, ifid_flush, idex_flush); end
      checks++; if (ifid_pc !== 64'h8000_0100 || ifid_inst !== 32'h0011_2233) begin errors++; $display("[TB] FAIL hold_release_data got %h/%h exp 80000100/00112233", ifid_pc, ifid_inst); end
      @(negedge clk);
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0104) begin errors++; $display("[TB] FAIL hold_next_addr got %0h/%h exp 1/80000104", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_redirect_hold();
      @(negedge clk);
      imem.imem_req_ready = 1'b1;
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'hdead_beef;
      ex_mem_read = 1'b1;
      ex_rd = 5'd6;
      id_rs1 = 5'd0;
      id_rs2 = 5'd6;
      #1;
      checks++; if (ifid_wen !== 1'b0 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL stall_rs2 got %0h/%0h exp 0/1", ifid_wen, idex_flush); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 64'h8000_0200;
      #1;
      checks++; if (ifid_wen !== 1'b1 || ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL redir_hold_ctl got %0h/%0h/%0h exp 1/1/1", ifid_wen, ifid_flush, idex_flush); end
      checks++; if (ifid_pc !== 64'h0 || ifid_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL redir_hold_nop got %h/%h exp 0/00000013", ifid_pc, ifid_inst); end
      @(negedge clk);
      redirect_valid = 1'b0;
      ex_mem_read = 1'b0;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0200) begin errors++; $display("[TB] FAIL redir_hold_addr got %0h/%h exp 1/80000200", imem.imem_req_valid, imem.imem_req_addr); end
      checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL redir_hold_discard got %0h/%0h exp 1/0", ifid_flush, idex_flush); end
   endtask

   task automatic test_x0_no_stall();
      @(negedge clk);
      imem.imem_req_ready = 1'b1;
      ex_mem_read = 1'b1;
      ex_rd = 5'd0;
      id_rs1 = 5'd0;
      id_rs2 = 5'd0;
      #1;
      checks++; if (idex_flush !== 1'b0 || ifid_wen !== 1'b1) begin errors++; $display("[TB] FAIL x0_req_ctl got %0h/%0h exp 0/1", idex_flush, ifid_wen); end
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'h0050_0293;
      #1;
      checks++; if (ifid_wen !== 1'b1 || ifid_flush !== 1'b0 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL x0_deliver_ctl got %0h/%0h/%0h exp 1/0/0", ifid_wen, ifid_flush, idex_flush); end
      checks++; if (ifid_pc !== 64'h8000_0200 || ifid_inst !== 32'h0050_0293) begin errors++; $display("[TB] FAIL x0_deliver_data got %h/%h exp 80000200/00500293", ifid_pc, ifid_inst); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      ex_mem_read = 1'b0;
      #1;
      checks++; if (imem.imem_req_addr !== 64'h8000_0204) begin errors++; $display("[TB] FAIL x0_next_addr got %h exp 80000204", imem.imem_req_addr); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      imem.imem_req_ready = 1'b1;
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b0 || ifid_flush !== 1'b1 || idex_flush !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out got %0h/%0h/%0h exp 0/1/0", imem.imem_req_valid, ifid_flush, idex_flush); end
      @(negedge clk);
      rst = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'hcafe_f00d;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL midrst_addr got %0h/%h exp 1/80000000", imem.imem_req_valid, imem.imem_req_addr); end
      checks++; if (ifid_flush !== 1'b1 || ifid_inst !== 32'h0000_0013) begin errors++; $display("[TB] FAIL midrst_stale got %0h/%h exp 1/00000013", ifid_flush, ifid_inst); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL midrst_still_req got %0h/%h exp 1/80000000", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      #1;
      checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin errors++; $display("[TB] FAIL wrap_redir_ctl got %0h/%0h exp 1/1", ifid_flush, idex_flush); end
      @(negedge clk);
      redirect_valid = 1'b0;
      imem.imem_req_ready = 1'b1;
      #1;
      checks++; if (imem.imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr got %h exp fffffffffffffffc", imem.imem_req_addr); end
      @(negedge clk);
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data = 32'h0000_0033;
      #1;
      checks++; if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_inst !== 32'h0000_0033 || ifid_flush !== 1'b0) begin errors++; $display("[TB] FAIL wrap_deliver got %h/%h/%0h exp fffffffffffffffc/00000033/0", ifid_pc, ifid_inst, ifid_flush); end
      @(negedge clk);
      imem.imem_rsp_valid = 1'b0;
      #1;
      checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 64'h0) begin errors++; $display("[TB] FAIL wrap_next_addr got %0h/%h exp 1/0", imem.imem_req_valid, imem.imem_req_addr); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fetch();
      test_redirect_wait();
      test_stall_hold();
      test_redirect_hold();
      test_x0_no_stall();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_ctrl.md
IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 64, width of all PC buses (matches ImmWidth).
REQ-002 Parameter INST_WIDTH, default 32, instruction width (matches InstWidth).
REQ-003 Parameter RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 imem_req_valid  out  1 / imem_req_ready  in  1 / imem_req_addr  out  PC_WIDTH  fetch request handshake.
REQ-007 imem_rsp_valid  in  1 / imem_rsp_data  in  INST_WIDTH  fetch response; no backpressure, one outstanding request maximum.
REQ-008 redirect_valid  in  1 / redirect_pc  in  PC_WIDTH  taken branch/jump from EX.
REQ-009 ex_mem_read  in  1 / ex_rd  in  5 / id_rs1  in  5 / id_rs2  in  5  load-use hazard inputs.
REQ-010 ifid_wen  out  1 / ifid_pc  out  PC_WIDTH / ifid_inst  out  INST_WIDTH  next-state controls for the IF/ID register.
REQ-011 ifid_flush  out  1  IF/ID loads NOP; idex_flush  out  1  ID/EX loads bubble.

Function
REQ-012 stall SHALL be ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2), combinational.
REQ-013 States SHALL be REQ, WAIT, DROP, HOLD; internal pc register and one-entry inst buffer.
REQ-014 REQ: imem_req_valid=1, imem_req_addr=pc; on ready -> WAIT; redirect without ready -> pc<=redirect_pc, stay REQ; redirect with ready -> pc<=redirect_pc, DROP.
REQ-015 WAIT: rsp_valid & redirect -> discard, pc<=redirect_pc, REQ; rsp_valid & !stall -> deliver, pc<=pc+4, REQ; rsp_valid & stall -> buffer, HOLD; !rsp_valid & redirect -> pc<=redirect_pc, DROP.
REQ-016 DROP: response on rsp_valid SHALL be discarded -> REQ; redirect in DROP updates pc, stays DROP unless rsp_valid same cycle.
REQ-017 HOLD: redirect -> discard buffer, pc<=redirect_pc, REQ; else !stall -> deliver buffer, pc<=pc+4, REQ; else stay HOLD.
REQ-018 Deliver SHALL mean ifid_wen=1, ifid_flush=0, ifid_pc=pc, ifid_inst=response or buffer, same cycle (zero latency).
REQ-019 stall & !redirect SHALL give ifid_wen=0, idex_flush=1, no delivery.
REQ-020 redirect_valid SHALL give ifid_wen=1, ifid_flush=1, idex_flush=1, priority over stall and delivery.
REQ-021 Otherwise with no delivery: ifid_wen=1, ifid_flush=1 (bubble), idex_flush=0.
REQ-022 ifid_inst SHALL equal NOP 32'h0000_0013 and ifid_pc 0 whenever ifid_flush=1.
REQ-023 pc+4 SHALL wrap modulo 2^PC_WIDTH; redirect_pc taken without alignment check.

Reset
REQ-024 While rst=1: all outputs 0 except ifid_flush=1, ifid_wen=1, ifid_inst=NOP.
REQ-025 Reset SHALL force pc<=RESET_PC, state<=REQ, buffer invalid, even mid-request; a response arriving in the first cycle after reset SHALL be ignored (not in WAIT).

Structure
REQ-026 NOP constant, PC/instruction widths in the shared defines include; state encoding local.
REQ-027 pc and buffer registers SHALL use the existing Reg sub-module; no other sub-module.

Verification
REQ-028 Reset then ready=1, rsp one cycle later each time with 0x00a00093 -> addresses 0x80000000, 0x80000004; IF/ID gets pc 0x80000000 inst 0x00a00093.
REQ-029 Redirect to 0x80000100 while in WAIT, rsp arrives next cycle -> response dropped, next request addr 0x80000100, ifid_flush=1 on redirect cycle.
REQ-030 ex_mem_read=1, ex_rd=5, id_rs1=5, rsp arrives -> ifid_wen=0, idex_flush=1, HOLD; stall drops -> buffered inst delivered, pc+4 fetched.
REQ-031 Redirect and stall same cycle in HOLD -> buffer discarded, ifid_flush=1, fetch from redirect_pc.
REQ-032 ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall.
REQ-033 rst asserted in WAIT -> next request addr 0x80000000, stale response ignored.
